// File: rtl/hs32_mem_sched_if.sv
// Requester and external memory bus bundle for the hs32 memory scheduler.
interface hs32_mem_sched_if #(
  parameter int unsigned NCH = 3
);
  // requester side
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    rwi;
  logic [NCH*32-1:0] addri;
  logic [NCH*32-1:0] dtw;
  logic [31:0]       dtr;
  logic [NCH-1:0]    ack;
  logic [NCH-1:0]    err;
  logic [1:0]        gnt;
  // external memory side
  logic [31:0]       addr;
  logic              rw;
  logic [31:0]       dout;
  logic [31:0]       din;
  logic              valid;
  logic              done;

  // scheduler view
  modport master (
    input  req, rwi, addri, dtw, din, done,
    output dtr, ack, err, gnt, addr, rw, dout, valid
  );

  // requester / memory model view
  modport slave (
    output req, rwi, addri, dtw, din, done,
    input  dtr, ack, err, gnt, addr, rw, dout, valid
  );
endinterface

// File: rtl/hs32_mem_sched.sv
// Shares one external memory bus between NCH requesters: fixed priority,
// starvation aging and a bus watchdog that aborts with an error flag.
module hs32_mem_sched #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned AGE_MAX = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  hs32_mem_sched_if.master bus
);

  localparam int unsigned AW = 8;
  localparam int unsigned WW = 8;
  localparam int unsigned GW = 2;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state, state_d;
  logic [NCH-1:0][AW-1:0] age, age_d;
  logic [WW-1:0]          wd, wd_d;
  logic                   valid_q, valid_d;
  logic                   rw_q, rw_d;
  logic [DW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          dout_q, dout_d;
  logic [DW-1:0]          dtr_q, dtr_d;
  logic [NCH-1:0]         ack_q, ack_d;
  logic [NCH-1:0]         err_q, err_d;
  logic [GW-1:0]          gnt_q, gnt_d;

  logic [GW-1:0]          pick, pick_req, pick_aged;
  logic                   req_hit, aged_hit;
  logic                   pick_rw;
  logic [DW-1:0]          pick_addr, pick_data;
  logic [NCH-1:0]         gnt_oh;

  // Channel choice: lowest-index starved channel, else lowest-index requester
  always_comb begin
    pick_req  = '0;
    pick_aged = '0;
    req_hit   = 1'b0;
    aged_hit  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!req_hit && bus.req[k]) begin
        req_hit  = 1'b1;
        pick_req = GW'(k);
      end
      if (!aged_hit && bus.req[k] && age[k] == AW'(AGE_MAX)) begin
        aged_hit  = 1'b1;
        pick_aged = GW'(k);
      end
    end
    pick = aged_hit ? pick_aged : pick_req;
  end

  // Fetch the chosen channel's direction, address and write data
  always_comb begin
    pick_rw   = 1'b0;
    pick_addr = '0;
    pick_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (pick == GW'(k)) begin
        pick_rw   = bus.rwi[k];
        pick_addr = bus.addri[DW*k +: DW];
        pick_data = bus.dtw[DW*k +: DW];
      end
    end
  end

  assign gnt_oh = NCH'(1) << gnt_q;

  // Next-state, next-output and aging logic
  always_comb begin
    state_d = state;
    valid_d = valid_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    dtr_d   = dtr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = '0;
    wd_d    = wd;
    age_d   = age;

    unique case (state)
      IDLE: begin
        if (req_hit) begin
          gnt_d   = pick;
          rw_d    = pick_rw;
          addr_d  = pick_addr;
          dout_d  = pick_data;
          valid_d = 1'b1;
          wd_d    = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // done takes precedence over a coincident watchdog expiry
        if (bus.done) begin
          valid_d = 1'b0;
          dtr_d   = rw_q ? '0 : bus.din;
          ack_d   = gnt_oh;
          state_d = RESP;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          valid_d = 1'b0;
          dtr_d   = '0;
          ack_d   = gnt_oh;
          err_d   = gnt_oh;
          state_d = RESP;
        end else begin
          wd_d = wd + WW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // waiting channels age; the active grant and idle channels do not
    for (int k = 0; k < NCH; k++) begin
      if (!bus.req[k]) begin
        age_d[k] = '0;
      end else if (state == IDLE && pick == GW'(k)) begin
        age_d[k] = '0;
      end else if (!(state != IDLE && gnt_q == GW'(k)) &&
                   age[k] != AW'(AGE_MAX)) begin
        age_d[k] = age[k] + AW'(1);
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      dtr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      wd      <= '0;
      age     <= '0;
    end else begin
      state   <= state_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      dtr_q   <= dtr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      wd      <= wd_d;
      age     <= age_d;
    end
  end

  assign bus.valid = valid_q;
  assign bus.rw    = rw_q;
  assign bus.addr  = addr_q;
  assign bus.dout  = dout_q;
  assign bus.dtr   = dtr_q;
  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_hs32_mem_sched.sv
// Self-checking bench for hs32_mem_sched: cycle model plus literal ack log.
module tb_hs32_mem_sched;

  localparam int NCH     = 3;
  localparam int AGE_MAX = 8;
  localparam int TIMEOUT = 255;
  localparam int TABN    = 16;
  localparam int LITN    = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  hs32_mem_sched_if #(.NCH(NCH)) bus ();

  hs32_mem_sched #(
    .NCH    (NCH),
    .AGE_MAX(AGE_MAX),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // counters
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int expired = 0;
  logic check_en  = 1'b0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;

  // per-channel request tables (main appends, driver consumes)
  logic        tab_rw[NCH][TABN];
  logic [31:0] tab_a [NCH][TABN];
  logic [31:0] tab_d [NCH][TABN];
  int cnt[NCH] = '{default: 0};
  int pos[NCH] = '{default: 0};

  // literal expected ack log
  int          lit_ch [LITN];
  logic        lit_err[LITN];
  logic [31:0] lit_dtr[LITN];
  int          lit_gap[LITN];
  int lit_n    = 0;
  int lit_pos  = 0;
  int last_ack = 0;

  // memory responder controls
  int   lat        = 1;
  logic force_done = 1'b0;
  logic auto_done  = 1'b0;
  int   vcnt       = 0;

  assign bus.done = auto_done | force_done;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ~a;
  endfunction

  // requester driver: advance a channel's table on its ack
  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (bus.ack[k] === 1'b1) pos[k] = pos[k] + 1;
      if (pos[k] < cnt[k]) begin
        bus.req[k]          = 1'b1;
        bus.rwi[k]          = tab_rw[k][pos[k]];
        bus.addri[32*k +: 32] = tab_a[k][pos[k]];
        bus.dtw[32*k +: 32]   = tab_d[k][pos[k]];
      end else begin
        bus.req[k]          = 1'b0;
        bus.rwi[k]          = 1'b0;
        bus.addri[32*k +: 32] = 32'h0;
        bus.dtw[32*k +: 32]   = 32'h0;
      end
    end
  end

  // memory responder: done in the lat-th cycle of valid (lat 0 = never)
  always @(negedge clk) begin
    if (bus.valid === 1'b1) vcnt = vcnt + 1;
    else vcnt = 0;
    auto_done = (lat != 0) && (bus.valid === 1'b1) && (vcnt == lat);
    bus.din   = rd_word(bus.addr);
  end

  // behavioural model of the scheduler, updated on each sampling edge
  int          m_phase;  // 0 waiting for work, 1 bus access, 2 response
  int          m_g;
  logic        m_valid, m_rw;
  logic [31:0] m_addr, m_dout, m_dtr;
  logic [NCH-1:0] m_ack, m_err;
  int          m_age[NCH];
  int          m_wd;
  int          pick;
  int          nage[NCH];

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = 0; m_g = 0; m_valid = 1'b0; m_rw = 1'b0;
      m_addr = 32'h0; m_dout = 32'h0; m_dtr = 32'h0;
      m_ack = '0; m_err = '0; m_wd = 0;
      for (int k = 0; k < NCH; k++) m_age[k] = 0;
    end else begin
      pick = -1;
      for (int k = 0; k < NCH; k++)
        if (pick < 0 && bus.req[k] === 1'b1 && m_age[k] == AGE_MAX) pick = k;
      for (int k = 0; k < NCH; k++)
        if (pick < 0 && bus.req[k] === 1'b1) pick = k;
      for (int k = 0; k < NCH; k++) begin
        if (bus.req[k] !== 1'b1) nage[k] = 0;
        else if (m_phase == 0 && pick == k) nage[k] = 0;
        else if (m_phase != 0 && m_g == k) nage[k] = m_age[k];
        else nage[k] = (m_age[k] < AGE_MAX) ? m_age[k] + 1 : AGE_MAX;
      end
      m_ack = '0;
      m_err = '0;
      case (m_phase)
        0: if (pick >= 0) begin
          m_g     = pick;
          m_rw    = bus.rwi[pick];
          m_addr  = bus.addri[32*pick +: 32];
          m_dout  = bus.dtw[32*pick +: 32];
          m_valid = 1'b1;
          m_wd    = 0;
          m_phase = 1;
        end
        1: if (bus.done === 1'b1) begin
          m_valid = 1'b0;
          m_dtr   = m_rw ? 32'h0 : bus.din;
          m_ack[m_g] = 1'b1;
          m_phase = 2;
        end else if (m_wd == TIMEOUT - 1) begin
          m_valid = 1'b0;
          m_dtr   = 32'h0;
          m_ack[m_g] = 1'b1;
          m_err[m_g] = 1'b1;
          m_phase = 2;
        end else begin
          m_wd = m_wd + 1;
        end
        default: m_phase = 0;
      endcase
      for (int k = 0; k < NCH; k++) m_age[k] = nage[k];
    end
  end

  // compare process: model every cycle, literal log on every ack
  int ch;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (check_en) begin
      n_tests = n_tests + 1;
      if (bus.valid !== m_valid || bus.rw !== m_rw || bus.addr !== m_addr ||
          bus.dout !== m_dout || bus.dtr !== m_dtr || bus.ack !== m_ack ||
          bus.err !== m_err || bus.gnt !== 2'(m_g)) begin
        n_fail = n_fail + 1;
        $display("FAIL cycle %0d outputs: got valid=%b rw=%b addr=%h dout=%h dtr=%h ack=%b err=%b gnt=%0d, expected valid=%b rw=%b addr=%h dout=%h dtr=%h ack=%b err=%b gnt=%0d",
                 cyc, bus.valid, bus.rw, bus.addr, bus.dout, bus.dtr, bus.ack, bus.err, bus.gnt,
                 m_valid, m_rw, m_addr, m_dout, m_dtr, m_ack, m_err, m_g);
      end
      if (bus.ack !== '0) begin
        n_tests = n_tests + 1;
        ch = -1;
        for (int k = 0; k < NCH; k++) if (bus.ack[k] === 1'b1 && ch < 0) ch = k;
        if (lit_pos >= lit_n) begin
          n_fail = n_fail + 1;
          $display("FAIL cycle %0d unexpected_ack: got ack=%b, expected none", cyc, bus.ack);
        end else if (ch != lit_ch[lit_pos] || (bus.err != '0) != lit_err[lit_pos] ||
                     bus.dtr !== lit_dtr[lit_pos] ||
                     (lit_gap[lit_pos] > 0 && cyc - last_ack != lit_gap[lit_pos])) begin
          n_fail = n_fail + 1;
          $display("FAIL cycle %0d ack_log[%0d]: got ch=%0d err=%b dtr=%h gap=%0d, expected ch=%0d err=%b dtr=%h gap=%0d",
                   cyc, lit_pos, ch, bus.err, bus.dtr, cyc - last_ack,
                   lit_ch[lit_pos], lit_err[lit_pos], lit_dtr[lit_pos], lit_gap[lit_pos]);
        end
        lit_pos  = lit_pos + 1;
        last_ack = cyc;
      end
    end
    if (final_req && !final_done) begin
      final_done = 1'b1;
      n_tests = n_tests + 2;
      if (lit_pos != lit_n) begin
        n_fail = n_fail + 1;
        $display("FAIL ack_count: got %0d acks, expected %0d", lit_pos, lit_n);
      end
      if (expired != 0) begin
        n_fail = n_fail + 1;
        $display("FAIL wait_bound: got %0d expired waits, expected 0", expired);
      end
    end
  end

  task automatic push_req(input int k, input logic rw, input logic [31:0] a,
                          input logic [31:0] d);
    tab_rw[k][cnt[k]] = rw;
    tab_a[k][cnt[k]]  = a;
    tab_d[k][cnt[k]]  = d;
    cnt[k] = cnt[k] + 1;
  endtask

  task automatic push_lit(input int k, input logic e, input logic [31:0] d,
                          input int gap);
    lit_ch[lit_n]  = k;
    lit_err[lit_n] = e;
    lit_dtr[lit_n] = d;
    lit_gap[lit_n] = gap;
    lit_n = lit_n + 1;
  endtask

  function automatic logic all_consumed();
    logic r = 1'b1;
    for (int k = 0; k < NCH; k++) if (pos[k] < cnt[k]) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input int budget);
    int spent = 0;
    while (!all_consumed() && spent < budget) begin
      @(negedge clk); #1;
      spent = spent + 1;
    end
    if (!all_consumed()) expired = expired + 1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // single read on channel 1, done in second bus cycle
    lat = 2;
    push_req(1, 1'b0, 32'h0000_0100, 32'h0);
    push_lit(1, 1'b0, 32'hDEAD_BEEF, 0);
    wait_idle(50);

    // three simultaneous requests, immediate done; ch0 is a write
    lat = 1;
    push_req(0, 1'b1, 32'h0000_0200, 32'h1234_5678);
    push_req(1, 1'b0, 32'h0000_0300, 32'h0);
    push_req(2, 1'b0, 32'h0000_0400, 32'h0);
    push_lit(0, 1'b0, 32'h0, 0);
    push_lit(1, 1'b0, ~32'h0000_0300, 3);
    push_lit(2, 1'b0, ~32'h0000_0400, 3);
    wait_idle(50);

    // starvation: ch0 back-to-back, ch2 steady; ch2 wins after aging
    push_req(0, 1'b0, 32'h0000_0010, 32'h0);
    push_req(0, 1'b0, 32'h0000_0014, 32'h0);
    push_req(0, 1'b0, 32'h0000_0018, 32'h0);
    push_req(0, 1'b0, 32'h0000_001C, 32'h0);
    push_req(2, 1'b0, 32'h0000_0500, 32'h0);
    push_lit(0, 1'b0, ~32'h0000_0010, 0);
    push_lit(0, 1'b0, ~32'h0000_0014, 3);
    push_lit(0, 1'b0, ~32'h0000_0018, 3);
    push_lit(2, 1'b0, ~32'h0000_0500, 3);
    push_lit(0, 1'b0, ~32'h0000_001C, 3);
    wait_idle(80);

    // watchdog abort, then normal service
    lat = 0;
    push_req(1, 1'b0, 32'h0000_0600, 32'h0);
    push_lit(1, 1'b1, 32'h0, 0);
    wait_idle(400);
    lat = 1;
    push_req(2, 1'b0, 32'h0000_0700, 32'h0);
    push_lit(2, 1'b0, ~32'h0000_0700, 0);
    wait_idle(50);

    // done lands in the last watchdog cycle: no error
    lat = TIMEOUT;
    push_req(0, 1'b0, 32'h0000_0800, 32'h0);
    push_lit(0, 1'b0, ~32'h0000_0800, 0);
    wait_idle(400);

    // reset while the bus is held, stray done in the first idle cycle
    lat = 0;
    push_req(1, 1'b0, 32'h0000_0900, 32'h0);
    repeat (10) @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    lat        = 2;
    reset      = 1'b1;
    force_done = 1'b1;
    @(negedge clk);
    #1 force_done = 1'b0;
    push_lit(1, 1'b0, ~32'h0000_0900, 0);
    wait_idle(50);
    push_req(0, 1'b1, 32'h0000_0A00, 32'hCAFE_F00D);
    push_lit(0, 1'b0, 32'h0, 0);
    wait_idle(50);

    final_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
